// File: rtl/cdb_writeback_arbiter_pkg.sv
// Shared result bundle carried from the functional units to writeback.
// Field widths match the rename table and ROB sizing.
package cdb_writeback_arbiter_pkg;

  localparam int PREG_BITS = 6;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
  } inst_t;

  typedef struct packed {
    logic [PREG_BITS-1:0] rd;
  } rat_t;

  typedef struct packed {
    logic [7:0] rob_id;
  } rob_t;

  typedef struct packed {
    inst_t inst;
    rat_t  rat;
    rob_t  rob;
  } inst_info_t;

  typedef struct packed {
    logic        ready_for_writeback;
    logic [31:0] register_value;
    inst_info_t  inst_info;
  } fu_output_t;

endpackage

// File: rtl/cdb_writeback_arbiter.sv
// Per-FU result FIFOs with a round-robin grant onto the common data bus.
// The granted head is registered into cdb_out together with a PRF write.
module cdb_writeback_arbiter
  import cdb_writeback_arbiter_pkg::*;
#(
  parameter int N_SRC  = 2,
  parameter int DEPTH  = 2,
  parameter int PREG_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  fu_output_t               fu_out [N_SRC],
  output logic [N_SRC-1:0]         fu_ready,
  output fu_output_t               cdb_out,
  output logic [$clog2(N_SRC)-1:0] cdb_src,
  output logic                     prf_we,
  output logic [PREG_W-1:0]        prf_rd,
  output logic [31:0]              prf_wdata,
  output logic [7:0]               prf_rob_id
);

  localparam int SW = $clog2(N_SRC);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fu_output_t      mem    [N_SRC][DEPTH];
  logic [PW-1:0]   wr_ptr [N_SRC];
  logic [PW-1:0]   rd_ptr [N_SRC];
  logic [CW-1:0]   count  [N_SRC];
  logic [SW-1:0]   rr_ptr;
  logic [SW-1:0]   winner;
  logic [SW-1:0]   idx;
  logic            win_valid;
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  fu_output_t      head;

  // Ready depends on registered occupancy only; no bypass from a pop.
  always_comb begin
    fu_ready = '0;
    push     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      fu_ready[i] = (count[i] != CW'(DEPTH));
      push[i]     = fu_out[i].ready_for_writeback && fu_ready[i] && !flush;
    end
  end

  always_comb begin
    win_valid = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = SW'((int'(rr_ptr) + k) % N_SRC);
      if (!win_valid && count[idx] != '0) begin
        win_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (win_valid && !flush) pop[winner] = 1'b1;
    head = mem[winner][rd_ptr[winner]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++)
        for (int j = 0; j < DEPTH; j++)
          mem[i][j] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++)
        if (push[i]) mem[i][wr_ptr[i]] <= fu_out[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (!flush && win_valid) begin
      rr_ptr <= (winner == SW'(N_SRC - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Data fields hold when idle; only the valid and write enable drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_out <= '0;
      cdb_src <= '0;
      prf_we  <= 1'b0;
    end else if (flush || !win_valid) begin
      cdb_out.ready_for_writeback <= 1'b0;
      prf_we                      <= 1'b0;
    end else begin
      cdb_out                     <= head;
      cdb_out.ready_for_writeback <= 1'b1;
      cdb_src                     <= winner;
      prf_we <= (head.inst_info.inst.rd_s != 5'd0);
    end
  end

  assign prf_rd     = PREG_W'(cdb_out.inst_info.rat.rd);
  assign prf_wdata  = cdb_out.register_value;
  assign prf_rob_id = cdb_out.inst_info.rob.rob_id;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts every CDB broadcast.
// A monitor pops predictions whenever the DUT broadcasts.
module tb_cdb_writeback_arbiter;
  import cdb_writeback_arbiter_pkg::*;

  localparam int N_SRC  = 2;
  localparam int DEPTH  = 2;
  localparam int PREG_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  fu_output_t       fu_out [N_SRC];
  logic [N_SRC-1:0] fu_ready;
  fu_output_t       cdb_out;
  logic [0:0]       cdb_src;
  logic             prf_we;
  logic [PREG_W-1:0] prf_rd;
  logic [31:0]      prf_wdata;
  logic [7:0]       prf_rob_id;

  cdb_writeback_arbiter #(
    .N_SRC(N_SRC), .DEPTH(DEPTH), .PREG_W(PREG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fu_out(fu_out), .fu_ready(fu_ready),
    .cdb_out(cdb_out), .cdb_src(cdb_src),
    .prf_we(prf_we), .prf_rd(prf_rd),
    .prf_wdata(prf_wdata), .prf_rob_id(prf_rob_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    fu_output_t r;
    int         src;
    int         cyc;
  } exp_t;

  exp_t       exp_q [$];
  fu_output_t mq [N_SRC][$];
  fu_output_t pend [N_SRC];
  bit         pend_v [N_SRC];
  int         rr = 0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         next_rob = 16;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic set_pend(input int s, input logic [4:0] rd_s,
                          input logic [5:0] prd, input logic [31:0] v,
                          input logic [7:0] rob);
    fu_output_t r;
    r = '0;
    r.ready_for_writeback = 1'b1;
    r.register_value = v;
    r.inst_info.inst.opcode = 7'($urandom);
    r.inst_info.inst.rd_s = rd_s;
    r.inst_info.rat.rd = prd;
    r.inst_info.rob.rob_id = rob;
    pend[s] = r;
    pend_v[s] = 1'b1;
  endtask

  // One cycle: drive at the falling edge, predict the next rising edge.
  task automatic step(input bit do_flush, input int p_new);
    bit rdy [N_SRC];
    int w;
    exp_t e;
    logic [95:0] junk;
    for (int i = 0; i < N_SRC; i++) begin
      if (!pend_v[i] && int'($urandom_range(99)) < p_new)
        set_pend(i, ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31, 1)),
                 6'($urandom), $urandom, 8'(next_rob++));
      junk = {$urandom, $urandom, $urandom};
      fu_out[i] = fu_output_t'(junk[$bits(fu_output_t)-1:0]);
      fu_out[i].ready_for_writeback = 1'b0;
      if (pend_v[i]) fu_out[i] = pend[i];
    end
    flush = do_flush;
    for (int i = 0; i < N_SRC; i++) begin
      rdy[i] = (mq[i].size() < DEPTH);
      check($sformatf("fu_ready[%0d]", i), fu_ready[i], rdy[i]);
    end
    if (do_flush) begin
      for (int i = 0; i < N_SRC; i++) begin
        mq[i].delete();
        pend_v[i] = 1'b0;
      end
    end else begin
      w = -1;
      for (int k = 0; k < N_SRC; k++)
        if (w < 0 && mq[(rr + k) % N_SRC].size() > 0) w = (rr + k) % N_SRC;
      if (w >= 0) begin
        e.r = mq[w].pop_front();
        e.src = w;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
        rr = (w + 1) % N_SRC;
      end
      for (int i = 0; i < N_SRC; i++)
        if (pend_v[i] && rdy[i]) begin
          mq[i].push_back(pend[i]);
          pend_v[i] = 1'b0;
        end
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_SRC; i++) begin
      mq[i].delete();
      pend_v[i] = 1'b0;
      fu_out[i] = '0;
    end
    exp_q.delete();
    rr = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_cdb_out"}, cdb_out, '0);
    check({tag, "_cdb_src"}, cdb_src, 0);
    check({tag, "_prf_we"}, prf_we, 0);
    check({tag, "_prf_rd"}, prf_rd, 0);
    check({tag, "_prf_wdata"}, prf_wdata, 0);
    check({tag, "_prf_rob_id"}, prf_rob_id, 0);
    check({tag, "_fu_ready"}, fu_ready, {N_SRC{1'b1}});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (cdb_out.ready_for_writeback) begin
          if (exp_q.size() == 0) begin
            check("unexpected_bcast", cdb_out.ready_for_writeback, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("bcast_cycle", cyc, e.cyc);
            check("cdb_src", cdb_src, e.src);
            check("cdb_out", cdb_out, e.r);
            check("prf_we", prf_we, e.r.inst_info.inst.rd_s != 5'd0);
            check("prf_rd", prf_rd, e.r.inst_info.rat.rd);
            check("prf_wdata", prf_wdata, e.r.register_value);
            check("prf_rob_id", prf_rob_id, e.r.inst_info.rob.rob_id);
          end
        end else begin
          check("idle_prf_we", prf_we, 1'b0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : driver
    model_reset();
    #3;
    check_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    set_pend(0, 5'd5, 6'd17, 32'hDEADBEEF, 8'd3);
    repeat (3) step(0, 0);
    set_pend(0, 5'd0, 6'd9, 32'h1234_5678, 8'd7);
    repeat (3) step(0, 0);

    repeat (4) step(0, 100);
    repeat (6) step(0, 0);

    repeat (30) step(0, 100);
    repeat (3) step(1, 100);
    repeat (6) step(0, 0);

    repeat (2000) step($urandom_range(49) == 0, int'($urandom_range(90, 30)));
    repeat (6) step(0, 0);

    set_pend(0, 5'd3, 6'd33, 32'hCAFE_F00D, 8'd9);
    step(0, 0);
    step(0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_pend(1, 5'd4, 6'd40, 32'h0000_0111, 8'd11);
    set_pend(0, 5'd6, 6'd41, 32'h0000_0222, 8'd12);
    repeat (4) step(0, 0);

    repeat (500) step($urandom_range(49) == 0, int'($urandom_range(100, 20)));
    repeat (10) step(0, 0);
    check("drain_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
